// File: rtl/pattern_match_ctrl.sv
`default_nettype none
// ============================================================================
//  pattern_match_ctrl
//  Run-time programmable serial pattern matcher with match counting and a
//  target count that ends the run.
//  Revision: 1.0
// ============================================================================
module pattern_match_ctrl #(
    parameter  int W  = 8,
    parameter  int CW = 8,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [W-1:0]  cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] target,
    input  logic          bit_valid,
    input  logic          bit_in,
    output logic          bit_ready,
    output logic          match,
    output logic [CW-1:0] match_count,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [W-1:0]  pattern_q, pattern_d;
    logic [LW-1:0] len_q,     len_d;
    logic          overlap_q, overlap_d;
    logic [W-1:0]  hist_q,    hist_d;
    logic [LW-1:0] fill_q,    fill_d;
    logic [CW-1:0] count_q,   count_d;
    logic [CW-1:0] target_q,  target_d;
    logic          match_q,   match_d;
    logic          cfg_err_q, cfg_err_d;

    logic          accept;
    logic [W-1:0]  hist_sh;
    logic [W-1:0]  len_mask;
    logic [LW:0]   fill_wide;
    logic [LW-1:0] fill_inc;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          len_ok;

    assign bit_ready   = (state_q == S_RUN) & ~abort;
    assign accept      = bit_valid & bit_ready;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match       = match_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = count_q;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        target_d  = target_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        hist_sh = {hist_q[W-2:0], bit_in};
        for (int i = 0; i < W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        // Fill saturates at the pattern length so it never overflows on long runs.
        fill_wide = {1'b0, fill_q} + (LW+1)'(1);
        fill_inc  = (fill_wide > {1'b0, len_q}) ? len_q : fill_wide[LW-1:0];
        hit       = (fill_inc >= len_q) && ((hist_sh & len_mask) == (pattern_q & len_mask));
        cnt_inc   = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
        len_ok    = (len_q != '0) && (int'(len_q) <= W);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    state_d   = S_IDLE;
                end else if (start) begin
                    if (len_ok) begin
                        state_d  = S_RUN;
                        hist_d   = '0;
                        fill_d   = '0;
                        count_d  = '0;
                        target_d = target;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cfg_we) begin
                    cfg_err_d = 1'b1;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    hist_d = hist_sh;
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        count_d = cnt_inc;
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            target_q  <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            target_q  <= target_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_match_ctrl.sv
`default_nettype none
// Scoreboard bench for pattern_match_ctrl: expected match / cfg_err events are
// queued by the stimulus and retired by a monitor when the DUT pulses them.
module tb_pattern_match_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int LW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [W-1:0]  cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] target = '0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_ready;
    logic          match;
    logic [CW-1:0] match_count;
    logic          busy;
    logic          done;
    logic          cfg_err;

    pattern_match_ctrl #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
        .target(target), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .match(match), .match_count(match_count), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  cnt;
        logic        dn;
    } exp_t;

    exp_t mq[$];
    int   eq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retires queued expectations whenever the DUT pulses an output.
    always @(posedge clk) begin
        #2;
        if (match) begin
            if (mq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_match: got match at cycle %0d count=%0d expected none", cyc, match_count);
            end else begin
                exp_t e;
                e = mq.pop_front();
                check("match_cycle", cyc, e.cyc);
                check("match_count_at_match", int'(match_count), int'(e.cnt));
                check("done_at_match", int'(done), int'(e.dn));
            end
        end
        if (cfg_err) begin
            if (eq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cfg_err: got pulse at cycle %0d expected none", cyc);
            end else begin
                check("cfg_err_cycle", cyc, eq.pop_front());
            end
        end
    end

    task automatic push_match(input int c, input int cnt, input logic dn);
        exp_t e;
        e.cyc = c;
        e.cnt = 8'(cnt);
        e.dn  = dn;
        mq.push_back(e);
    endtask

    task automatic do_cfg(input logic [W-1:0] p, input logic [LW-1:0] l, input logic o, input logic exp_err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        if (exp_err) eq.push_back(cyc + 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic exp_err);
        @(negedge clk);
        start = 1'b1;
        if (exp_err) eq.push_back(cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic exp_m, input int cnt, input logic dn);
        @(negedge clk);
        bit_valid = 1'b1; bit_in = b;
        if (exp_m) push_match(cyc + 1, cnt, dn);
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_match", int'(match), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_bit_ready", int'(bit_ready), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: overlapping 1001 in 1001001 -> two matches, run continues
        do_cfg(8'b0000_1001, 4'd4, 1'b1, 1'b0);
        target = 8'd0;
        do_start(1'b0);
        check("t1_busy", int'(busy), 1);
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 2, 0);
        idle(2);
        check("t1_count", int'(match_count), 2);
        check("t1_busy_after", int'(busy), 1);
        check("t1_queue_empty", mq.size(), 0);
        do_abort();
        check("t1_abort_idle", int'(busy), 0);
        check("t1_count_retained", int'(match_count), 2);

        // 2: non-overlapping, 1001001001 -> matches at bits 4 and 10
        do_cfg(8'b0000_1001, 4'd4, 1'b0, 1'b0);
        do_start(1'b0);
        check("t2_count_cleared", int'(match_count), 0);
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 2, 0);
        idle(2);
        check("t2_count", int'(match_count), 2);
        do_abort();

        // 3: overlap, target 2 -> DONE on second match, further bits ignored
        do_cfg(8'b0000_1001, 4'd4, 1'b1, 1'b0);
        target = 8'd2;
        do_start(1'b0);
        target = 8'd0;
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 2, 1);
        check("t3_done", int'(done), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_bit_ready", int'(bit_ready), 0);
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0);
        idle(2);
        check("t3_count_held", int'(match_count), 2);
        check("t3_done_held", int'(done), 1);
        do_cfg(8'b0000_1001, 4'd4, 1'b1, 1'b0);
        check("t3_cfg_to_idle", int'(done), 0);

        // 4: cfg write during RUN is rejected; illegal lengths rejected at start
        do_start(1'b0);
        do_cfg(8'hFF, 4'd8, 1'b0, 1'b1);
        check("t4_still_busy", int'(busy), 1);
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        idle(1);
        do_abort();
        do_cfg(8'h01, 4'd0, 1'b0, 1'b0);
        do_start(1'b1);
        check("t4_len0_idle", int'(busy), 0);
        do_cfg(8'h01, 4'd9, 1'b0, 1'b0);
        do_start(1'b1);
        check("t4_len9_idle", int'(busy), 0);
        idle(1);
        check("t4_err_queue_empty", eq.size(), 0);

        // Same-cycle cfg_we and start: config loads, start ignored
        @(negedge clk);
        cfg_we = 1'b1; start = 1'b1;
        cfg_pattern = 8'b0000_1001; cfg_len = 4'd4; cfg_overlap = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        check("cfg_start_same_cycle_idle", int'(busy), 0);

        // 5: abort beats an offered bit; history cleared on restart
        do_start(1'b0);
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        @(negedge clk);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        #1;
        check("t5_ready_low_on_abort", int'(bit_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0; bit_valid = 1'b0;
        check("t5_idle", int'(busy), 0);
        check("t5_count", int'(match_count), 0);
        do_start(1'b0);
        send_bit(1, 0, 0, 0);
        idle(2);
        check("t5_no_match_after_restart", int'(match_count), 0);

        // 6: async reset mid-run while match is high
        send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_count", int'(match_count), 0);
        check("t6_rst_match", int'(match), 0);
        @(negedge clk);
        rst = 1'b0;
        do_cfg(8'hA5, 4'd8, 1'b0, 1'b0);
        do_start(1'b0);
        send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 0);
        idle(2);
        check("t6_a5_count", int'(match_count), 1);
        check("final_match_queue_empty", mq.size(), 0);
        check("final_err_queue_empty", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
